// File: rtl/apb_axi_bridge_pkg.sv
// Shared types and helpers for the APB-to-AXI4-Lite bridge: FSM state
// encoding, AXI response codes and the response-to-error mapping.
package apb_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } bridge_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both map onto PSLVERR; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/apb_to_axi4lite_bridge.sv
// APB responder in front of an AXI4-Lite initiator. Every APB transfer
// becomes exactly one AXI4-Lite write or read; PREADY is withheld until the
// AXI response has returned. Only one transaction is ever in flight.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for an APB setup phase; request fields latched there
// ST_WR_REQ  | AW and W offered; each dropped on its own handshake
// ST_WR_RESP | both write handshakes done, bready high, waiting for B
// ST_RD_REQ  | AR offered, waiting for arready
// ST_RD_RESP | rready high, waiting for R
// ST_DONE    | pready high for exactly one cycle with pslverr from response
module apb_to_axi4lite_bridge
    import apb_axi_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,

    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [ADDR_WIDTH-1:0]     paddr_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]   pstrb_i,
    input  logic [2:0]                pprot_i,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [DATA_WIDTH-1:0]     prdata_o,

    output logic                      awvalid_o,
    input  logic                      awready_i,
    output logic [ADDR_WIDTH-1:0]     awaddr_o,
    output logic [2:0]                awprot_o,

    output logic                      wvalid_o,
    input  logic                      wready_i,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic [DATA_WIDTH/8-1:0]   wstrb_o,

    input  logic                      bvalid_i,
    output logic                      bready_o,
    input  logic [1:0]                bresp_i,

    output logic                      arvalid_o,
    input  logic                      arready_i,
    output logic [ADDR_WIDTH-1:0]     araddr_o,
    output logic [2:0]                arprot_o,

    input  logic                      rvalid_i,
    output logic                      rready_o,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    input  logic [1:0]                rresp_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    bridge_state_e           state_q;

    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic                    awvalid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [2:0]              awprot_q;
    logic                    wvalid_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    bready_q;

    logic                    arvalid_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [2:0]              arprot_q;
    logic                    rready_q;

    // AW and W complete independently; these remember which one already has.
    logic                    aw_done_q;
    logic                    w_done_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    aw_fin;
    logic                    w_fin;

    // Channel handshakes as seen at the coming clock edge.
    always_comb begin
        aw_hs  = awvalid_q & awready_i;
        w_hs   = wvalid_q & wready_i;
        b_hs   = bvalid_i & bready_q;
        ar_hs  = arvalid_q & arready_i;
        r_hs   = rvalid_i & rready_q;
        aw_fin = aw_done_q | aw_hs;
        w_fin  = w_done_q | w_hs;
    end

    // Bridge FSM with its request/response registers; all outputs registered.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awprot_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arprot_q  <= '0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            pready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // penable without a preceding setup phase never starts a transfer
                    if (psel_i && !penable_i) begin
                        if (pwrite_i) begin
                            awaddr_q  <= paddr_i;
                            awprot_q  <= pprot_i;
                            wdata_q   <= pwdata_i;
                            wstrb_q   <= pstrb_i;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            araddr_q  <= paddr_i;
                            arprot_q  <= pprot_i;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (b_hs) begin
                        bready_q  <= 1'b0;
                        pslverr_q <= resp_is_err(bresp_i);
                        pready_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end

                ST_RD_REQ: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_RESP;
                    end
                end

                ST_RD_RESP: begin
                    if (r_hs) begin
                        rready_q  <= 1'b0;
                        prdata_q  <= rdata_i;
                        pslverr_q <= resp_is_err(rresp_i);
                        pready_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // prdata is deliberately left alone so it holds until the next read
                    pslverr_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign prdata_o  = prdata_q;
    assign awvalid_o = awvalid_q;
    assign awaddr_o  = awaddr_q;
    assign awprot_o  = awprot_q;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign bready_o  = bready_q;
    assign arvalid_o = arvalid_q;
    assign araddr_o  = araddr_q;
    assign arprot_o  = arprot_q;
    assign rready_o  = rready_q;

endmodule

// File: tb/tb_apb_to_axi4lite_bridge.sv
// Bench for the APB-to-AXI4-Lite bridge: an APB master driver, an AXI4-Lite
// memory slave with programmable per-channel delays, a transaction-level
// reference model and scoreboards on both the APB and AXI sides.
module tb_apb_to_axi4lite_bridge;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;

    apb_to_axi4lite_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
        .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
        .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awprot_o(awprot),
        .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata), .wstrb_o(wstrb),
        .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp),
        .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arprot_o(arprot),
        .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { logic err; logic [DW-1:0] rdata; } apb_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; logic [2:0] prot; } axi_req_t;

    apb_exp_t apb_q[$];
    axi_req_t aw_q[$];
    axi_req_t ar_q[$];

    // Reference model: its own memory image and the last read value.
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] ref_last_rd;
    // AXI slave memory, updated only from what the bridge actually sends.
    logic [DW-1:0] slv_mem [64];

    bit       resp_ovr_en;
    logic [1:0] resp_ovr;

    // Response for an address: upper region bits pick OKAY/EXOKAY/SLVERR/DECERR.
    function automatic logic [1:0] resp_for(input logic [AW-1:0] a);
        return resp_ovr_en ? resp_ovr : a[11:10];
    endfunction

    // ---------------- AXI slave model ----------------
    int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit  aw_got, w_got, ar_got;
    bit  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int  wv_cycles;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [2:0]    cap_awprot, cap_arprot;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;

    task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
        aw_cnt = a; w_cnt = w; b_cnt = b; ar_cnt = ar; r_cnt = r;
    endtask

    task automatic slave_step();
        axi_req_t e;
        logic [1:0] rs;
        if (!resetn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            return;
        end
        // consequences of handshakes at the edge that just passed
        if (aw_hs) begin awready = 0; aw_got = 1; end
        if (w_hs)  begin wready = 0; w_got = 1; end
        if (b_hs)  begin bvalid = 0; aw_got = 0; w_got = 0; end
        if (ar_hs) begin arready = 0; ar_got = 1; end
        if (r_hs)  begin rvalid = 0; ar_got = 0; end

        if (aw_got) check("awvalid_not_reraised", awvalid, 0);
        if (w_got)  check("wvalid_not_reraised", wvalid, 0);
        if (bready) check("bready_after_aw_and_w", aw_got && w_got, 1);
        if (arvalid || rready || ar_got) check("no_write_while_read", {awvalid, wvalid, bready}, 0);
        if (wvalid) wv_cycles++;

        if (awvalid && !aw_got && !awready) begin
            if (aw_cnt == 0) begin awready = 1; cap_awaddr = awaddr; cap_awprot = awprot; end
            else aw_cnt--;
        end
        if (wvalid && !w_got && !wready) begin
            if (w_cnt == 0) begin wready = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
            else w_cnt--;
        end
        if (aw_got && w_got && !bvalid) begin
            if (b_cnt == 0) begin
                check("aw_expected_present", aw_q.size() != 0, 1);
                if (aw_q.size() != 0) begin
                    e = aw_q.pop_front();
                    check("awaddr", cap_awaddr, e.addr);
                    check("awprot", cap_awprot, e.prot);
                    check("wdata", cap_wdata, e.data);
                    check("wstrb", cap_wstrb, e.strb);
                end
                rs = resp_for(cap_awaddr);
                if (rs < 2) begin
                    for (int b = 0; b < SW; b++)
                        if (cap_wstrb[b]) slv_mem[cap_awaddr[7:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                end
                bvalid = 1; bresp = rs;
            end else b_cnt--;
        end
        if (arvalid && !ar_got && !arready) begin
            if (ar_cnt == 0) begin arready = 1; cap_araddr = araddr; cap_arprot = arprot; end
            else ar_cnt--;
        end
        if (ar_got && !rvalid) begin
            if (r_cnt == 0) begin
                check("ar_expected_present", ar_q.size() != 0, 1);
                if (ar_q.size() != 0) begin
                    e = ar_q.pop_front();
                    check("araddr", cap_araddr, e.addr);
                    check("arprot", cap_arprot, e.prot);
                end
                rvalid = 1; rdata = slv_mem[cap_araddr[7:2]]; rresp = resp_for(cap_araddr);
            end else r_cnt--;
        end

        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            slave_step();
        end
    end

    // ---------------- APB response monitor ----------------
    bit prev_pready = 0;
    initial begin
        apb_exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (pready) begin
                    check("pready_single_cycle", prev_pready, 0);
                    check("apb_expected_present", apb_q.size() != 0, 1);
                    if (apb_q.size() != 0) begin
                        e = apb_q.pop_front();
                        check("pslverr", pslverr, e.err);
                        check("prdata", prdata, e.rdata);
                    end
                end else begin
                    check("pslverr_low_without_pready", pslverr, 0);
                end
                prev_pready = pready;
            end else begin
                prev_pready = 0;
            end
        end
    end

    // ---------------- APB master with model update ----------------
    task automatic apb_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic [2:0] prot, input bit drop_psel,
                            output int lat);
        apb_exp_t e;
        axi_req_t r;
        logic [1:0] rs;
        rs = resp_for(addr);
        e.err = (rs >= 2);
        r.addr = addr; r.prot = prot;
        if (wr) begin
            r.data = data; r.strb = strb;
            aw_q.push_back(r);
            if (!e.err)
                for (int b = 0; b < SW; b++)
                    if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
            e.rdata = ref_last_rd;
        end else begin
            r.data = '0; r.strb = '0;
            ar_q.push_back(r);
            e.rdata = ref_mem[addr[7:2]];
            ref_last_rd = e.rdata;
        end
        apb_q.push_back(e);
        wv_cycles = 0;

        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (pready) break;
            if (drop_psel && lat == 1) begin psel = 0; penable = 0; end
            if (lat >= 200) begin
                check("pready_timeout", pready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids_readies"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
        check({tag, "_pready_pslverr"}, {pready, pslverr}, 0);
        check({tag, "_prdata"}, prdata, 0);
        check({tag, "_awaddr_araddr"}, {awaddr, araddr}, 0);
        check({tag, "_wdata_wstrb_prot"}, {wdata, wstrb, awprot, arprot}, 0);
    endtask

    int lat;
    initial begin
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0; rdata = '0; rresp = '0;
        resp_ovr_en = 0; resp_ovr = 2'b00; ref_last_rd = '0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 32'hA500_0000 + i * 32'h0001_0101;
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[16] = 32'h1234_5678;
        slv_mem[16] = 32'h1234_5678;
        set_delays(0, 0, 0, 0, 0);

        resetn = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1;
        @(posedge clk); #1;

        // zero-wait write
        resp_ovr_en = 1; resp_ovr = 2'b00;
        set_delays(0, 0, 0, 0, 0);
        apb_xfer(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, lat);
        check("zero_wait_write_latency", lat, 3);

        // AW accepted at once, W held off for four cycles
        set_delays(0, 4, 0, 0, 0);
        apb_xfer(1, 32'h0000_0014, 32'h0BAD_F00D, 4'h5, 3'b010, 0, lat);
        check("split_wvalid_cycles", wv_cycles, 5);

        // read with SLVERR after two arready waits
        resp_ovr = 2'b10;
        set_delays(0, 0, 0, 2, 0);
        apb_xfer(0, 32'h0000_0040, '0, '0, 3'b001, 0, lat);

        // DECERR write, then back-to-back OKAY read
        resp_ovr = 2'b11;
        set_delays(0, 0, 0, 0, 0);
        apb_xfer(1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, lat);
        resp_ovr = 2'b00;
        set_delays(0, 0, 0, 0, 0);
        apb_xfer(0, 32'h0000_0010, '0, '0, 3'b000, 0, lat);
        check("zero_wait_read_latency", lat, 3);

        // psel dropped early: transaction still completes, next one works
        set_delays(1, 2, 3, 0, 0);
        apb_xfer(1, 32'h0000_0018, 32'h5555_AAAA, 4'hC, 3'b100, 1, lat);
        set_delays(0, 0, 0, 1, 1);
        apb_xfer(0, 32'h0000_0018, '0, '0, 3'b000, 0, lat);

        // reset while waiting in WR_RESP
        set_delays(0, 0, 8, 0, 0);
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h0000_0030; pwdata = 32'h7777_7777; pstrb = 4'hF; pprot = '0;
        @(posedge clk); #1;
        penable = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bready) break;
        end
        check("reach_wr_resp", bready, 1);
        #2 resetn = 0;
        #1 check_reset_outputs("async_reset");
        psel = 0; penable = 0;
        repeat (2) @(posedge clk);
        apb_q.delete(); aw_q.delete(); ar_q.delete();
        ref_last_rd = '0;
        #1 resetn = 1;
        @(posedge clk); #1;
        set_delays(0, 0, 0, 0, 0);
        apb_xfer(0, 32'h0000_0030, '0, '0, 3'b000, 0, lat);
        check("post_reset_read_latency", lat, 3);

        // spurious penable without setup phase
        psel = 1; penable = 1; pwrite = 1; paddr = 32'h0000_0004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spurious_no_axi_valid", {awvalid, wvalid, arvalid}, 0);
            check("spurious_no_pready", pready, 0);
        end
        @(posedge clk); #1;
        psel = 0; penable = 0;
        @(posedge clk); #1;

        // randomized traffic with region-based responses
        resp_ovr_en = 0;
        for (int n = 0; n < 150; n++) begin
            int region_sel;
            logic [1:0] region;
            logic [AW-1:0] a;
            region_sel = $urandom_range(0, 9);
            region = (region_sel == 6) ? 2'b01 : (region_sel == 7) ? 2'b10 :
                     (region_sel == 8) ? 2'b11 : 2'b00;
            a = {20'($urandom), region, 2'b00, 6'($urandom_range(0, 63)), 2'b00};
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            apb_xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), 3'($urandom), 0, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        check("apb_queue_drained", apb_q.size(), 0);
        check("aw_queue_drained", aw_q.size(), 0);
        check("ar_queue_drained", ar_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
